// File: rtl/ejtag_data_shifter.sv
// EJTAG data-register shift stage.
// Captures the data-out mux readback word, shifts it out LSB-first on TDO
// while shifting TDI in, and hands the shifted-in word to the write path
// on an Update-DR strobe. All TAP events are single-cycle strobes already
// synchronised to CORE_CLOCK.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no scan in progress; shift/update strobes are protocol errors
// CAPWAIT | waiting out the data-out mux latency before sampling EJDO_DATA
// SHIFT   | shift register loaded; accepting shift and update strobes
module ejtag_data_shifter #(
  parameter int WIDTH         = 32,
  parameter int CAPTURE_DELAY = 1
) (
  input  logic             CORE_CLOCK,
  input  logic             RESET_D1_R_N,
  input  logic [WIDTH-1:0] EJDO_DATA,
  input  logic             EJTS_CAPTURE,
  input  logic             EJTS_SHIFT,
  input  logic             EJTS_UPDATE,
  input  logic             EJTS_TDI,
  input  logic             EJTS_BYPASS,
  output logic             EJSH_TDO,
  output logic [WIDTH-1:0] EJSH_DATA,
  output logic             EJSH_UPDATE,
  output logic             EJSH_BUSY,
  output logic             EJSH_ERR,
  output logic [5:0]       EJSH_COUNT
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPWAIT = 2'd1,
    ST_SHIFT   = 2'd2
  } state_e;

  localparam logic [1:0] DLY      = 2'(CAPTURE_DELAY);
  localparam logic [5:0] CNT_MAX  = 6'd63;
  localparam logic [5:0] CNT_FULL = 6'(WIDTH);

  state_e           state_q;
  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] data_q;
  logic             byp_q;
  logic [5:0]       count_q;
  logic [1:0]       wait_q;
  logic             upd_q;
  logic             err_q;

  logic cap_acc;
  logic upd_acc;
  logic sft_acc;
  logic multi;

  // Strobe arbitration: capture beats update beats shift; losers are dropped.
  always_comb begin
    cap_acc = EJTS_CAPTURE;
    upd_acc = EJTS_UPDATE & ~EJTS_CAPTURE;
    sft_acc = EJTS_SHIFT & ~EJTS_CAPTURE & ~EJTS_UPDATE;
    multi   = (EJTS_CAPTURE & EJTS_UPDATE) |
              (EJTS_CAPTURE & EJTS_SHIFT)  |
              (EJTS_UPDATE  & EJTS_SHIFT);
  end

  // Scan FSM, shift register, update word and status flags.
  always_ff @(posedge CORE_CLOCK) begin
    if (!RESET_D1_R_N) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
      data_q  <= '0;
      byp_q   <= 1'b0;
      count_q <= '0;
      wait_q  <= '0;
      upd_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      upd_q <= 1'b0;
      if (cap_acc) begin
        byp_q   <= EJTS_BYPASS;
        count_q <= '0;
        if (DLY == 2'd0) begin
          // No mux latency to cover: load in the strobe cycle itself.
          sr_q    <= EJTS_BYPASS ? '0 : EJDO_DATA;
          err_q   <= 1'b0;
          state_q <= ST_SHIFT;
        end else begin
          wait_q  <= DLY;
          state_q <= ST_CAPWAIT;
        end
      end else begin
        case (state_q)
          ST_CAPWAIT: begin
            if (wait_q == 2'd1) begin
              sr_q    <= byp_q ? '0 : EJDO_DATA;
              err_q   <= 1'b0;
              wait_q  <= '0;
              state_q <= ST_SHIFT;
            end else begin
              wait_q <= wait_q - 2'd1;
            end
            // A strobe landing on the load edge still counts as an error,
            // so it must win over the clear above.
            if (upd_acc || sft_acc) err_q <= 1'b1;
          end
          ST_SHIFT: begin
            if (upd_acc) begin
              if (!byp_q) begin
                data_q <= sr_q;
                upd_q  <= 1'b1;
                if (count_q != CNT_FULL) err_q <= 1'b1;
              end
              state_q <= ST_IDLE;
            end else if (sft_acc) begin
              if (byp_q) sr_q[0] <= EJTS_TDI;
              else       sr_q    <= {EJTS_TDI, sr_q[WIDTH-1:1]};
              if (count_q != CNT_MAX) count_q <= count_q + 6'd1;
            end
          end
          default: begin
            if (upd_acc || sft_acc) err_q <= 1'b1;
          end
        endcase
      end
      // Collisions flag an error regardless of which strobe was taken.
      if (multi) err_q <= 1'b1;
    end
  end

  assign EJSH_TDO    = sr_q[0];
  assign EJSH_DATA   = data_q;
  assign EJSH_UPDATE = upd_q;
  assign EJSH_BUSY   = (state_q == ST_CAPWAIT);
  assign EJSH_ERR    = err_q;
  assign EJSH_COUNT  = count_q;

`ifndef SYNTHESIS
  // Report strobe collisions from the TAP synchroniser.
  always @(posedge CORE_CLOCK) begin
    if (RESET_D1_R_N && multi)
      $warning("ejtag_data_shifter: multiple TAP strobes in one cycle");
  end

  if (CAPTURE_DELAY > 3) begin : g_bad_delay
    // Flag an out-of-range capture delay as soon as the clock runs.
    always @(posedge CORE_CLOCK) begin
      $error("ejtag_data_shifter: CAPTURE_DELAY=%0d exceeds 3", CAPTURE_DELAY);
    end
  end
`endif

endmodule

// File: tb/tb_ejtag_data_shifter.sv
// Scoreboard bench for ejtag_data_shifter: a transaction-level model
// (bit queue per scan) predicts TDO bits and update words; a monitor
// compares them whenever the DUT presents a shift or an update pulse.
module tb_ejtag_data_shifter;
  localparam int W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [W-1:0]  ejdo;
  logic          cap, sft, upd, tdi, byp;
  logic          tdo, updo, busy, err;
  logic [W-1:0]  dout;
  logic [5:0]    cnt;

  ejtag_data_shifter #(.WIDTH(W), .CAPTURE_DELAY(1)) dut (
    .CORE_CLOCK   (clk),
    .RESET_D1_R_N (rst_n),
    .EJDO_DATA    (ejdo),
    .EJTS_CAPTURE (cap),
    .EJTS_SHIFT   (sft),
    .EJTS_UPDATE  (upd),
    .EJTS_TDI     (tdi),
    .EJTS_BYPASS  (byp),
    .EJSH_TDO     (tdo),
    .EJSH_DATA    (dout),
    .EJSH_UPDATE  (updo),
    .EJSH_BUSY    (busy),
    .EJSH_ERR     (err),
    .EJSH_COUNT   (cnt)
  );

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [W-1:0] data;
    logic         err;
  } upd_t;

  upd_t upd_q[$];
  logic tdo_q[$];
  logic shift_tag = 1'b0;

  // reference model state
  logic         m_bits[$];
  logic         m_active, m_byp, m_bypbit, m_err;
  int           m_shifts;
  logic [W-1:0] m_data;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor: compare on update pulses and on accepted shift strobes
  upd_t mon_e;
  logic prev_upd = 1'b0;
  always @(negedge clk) begin
    if (updo) begin
      chk("upd_not_consecutive", 32'(prev_upd), 32'd0);
      checks++;
      if (upd_q.size() == 0) begin
        failures++;
        $display("FAIL upd_unexpected: got pulse data=%h expected no pulse", dout);
      end else begin
        mon_e = upd_q.pop_front();
        chk("upd_data", dout, mon_e.data);
        chk("upd_err", 32'(err), 32'(mon_e.err));
      end
    end
    prev_upd = updo;
    if (sft && shift_tag) begin
      checks++;
      if (tdo_q.size() == 0) begin
        failures++;
        $display("FAIL tdo_underflow: got tdo=%0b expected none", tdo);
      end else if (tdo !== tdo_q[0]) begin
        failures++;
        $display("FAIL tdo: got %0b expected %0b", tdo, tdo_q[0]);
        void'(tdo_q.pop_front());
      end else begin
        void'(tdo_q.pop_front());
      end
    end
  end

  task automatic cycle(logic c, logic s, logic u, logic t, logic tag);
    cap = c; sft = s; upd = u; tdi = t; shift_tag = tag;
    @(posedge clk); #1;
    cap = 1'b0; sft = 1'b0; upd = 1'b0; shift_tag = 1'b0;
  endtask

  function automatic int sat_count();
    return (m_shifts > 63) ? 63 : m_shifts;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    m_active = 1'b0; m_err = 1'b0; m_shifts = 0; m_data = '0;
    chk("rst_tdo", 32'(tdo), 32'd0);
    chk("rst_data", dout, 32'd0);
    chk("rst_update", 32'(updo), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_count", 32'(cnt), 32'd0);
  endtask

  // coll: shift strobe alongside capture; sinw: shift strobe during CAPWAIT
  task automatic do_capture(logic [W-1:0] d0, logic [W-1:0] d1, logic b,
                            logic coll, logic sinw);
    logic [W-1:0] dv;
    byp  = b;
    ejdo = d0;
    cycle(1'b1, coll, 1'b0, 1'b0, 1'b0);
    byp = ~b;
    chk("cap_busy", 32'(busy), 32'd1);
    chk("cap_err", 32'(err), 32'(m_err | coll));
    ejdo = d1;
    cycle(1'b0, sinw, 1'b0, 1'($urandom), 1'b0);
    m_active = 1'b1; m_byp = b; m_bypbit = 1'b0; m_shifts = 0;
    m_err = sinw;
    m_bits.delete();
    dv = b ? '0 : d1;
    for (int i = 0; i < W; i++) m_bits.push_back(dv[i]);
    chk("load_busy", 32'(busy), 32'd0);
    chk("load_err", 32'(err), 32'(m_err));
    chk("load_count", 32'(cnt), 32'd0);
    chk("load_tdo", 32'(tdo), 32'(dv[0]));
  endtask

  task automatic do_shift(logic t);
    logic tag;
    tag = m_active;
    if (m_active) begin
      tdo_q.push_back(m_byp ? m_bypbit : m_bits[0]);
      if (m_byp) m_bypbit = t;
      else begin
        void'(m_bits.pop_front());
        m_bits.push_back(t);
      end
      m_shifts++;
    end else begin
      m_err = 1'b1;
    end
    cycle(1'b0, 1'b1, 1'b0, t, tag);
  endtask

  task automatic do_update();
    logic [W-1:0] d;
    if (m_active) begin
      if (!m_byp) begin
        for (int i = 0; i < W; i++) d[i] = m_bits[i];
        m_err = m_err | (m_shifts != W);
        upd_q.push_back('{data: d, err: m_err});
        m_data = d;
      end
      m_active = 1'b0;
    end else begin
      m_err = 1'b1;
    end
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("upd_err_after", 32'(err), 32'(m_err));
    chk("upd_count_after", 32'(cnt), 32'(sat_count()));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] w;
    int n;
    rst_n = 1'b0; ejdo = '0; cap = 1'b0; sft = 1'b0; upd = 1'b0;
    tdi = 1'b0; byp = 1'b0;
    do_reset();

    // normal read
    do_capture(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < W; i++) do_shift(1'b0);
    do_update();
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("read_data", dout, 32'd0);

    // write
    w = 32'h1234_5678;
    do_capture($urandom, 32'hCAFE_F00D, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < W; i++) do_shift(w[i]);
    do_update();
    chk("write_data", dout, 32'h1234_5678);

    // short shift, then capture clears ERR
    do_capture(32'h0F0F_0F0F, 32'h0F0F_0F0F, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) do_shift(1'($urandom));
    do_update();
    chk("short_err", 32'(err), 32'd1);
    chk("short_count", 32'(cnt), 32'd8);
    do_capture(32'h1111_2222, 32'h1111_2222, 1'b0, 1'b0, 1'b0);
    do_update();

    // bypass
    do_capture(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    do_shift(1'b1); do_shift(1'b0); do_shift(1'b1);
    do_update();
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("byp_data_held", dout, m_data);

    // collisions and late data
    do_capture(32'h5555_0000, 32'h5555_0000, 1'b0, 1'b1, 1'b0);
    do_capture(32'h0, 32'hA5A5_A5A5, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < W; i++) do_shift(1'($urandom));
    do_update();

    // idle strobes are errors
    do_capture(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < W; i++) do_shift(1'b1);
    do_update();
    chk("clean_err", 32'(err), 32'd0);
    do_shift(1'b0);
    chk("idle_shift_err", 32'(err), 32'd1);
    chk("idle_shift_count", 32'(cnt), 32'd32);

    // reset mid-shift
    do_capture(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) do_shift(1'b1);
    do_reset();
    do_update();
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("post_rst_no_pulse", 32'(updo), 32'd0);
    chk("post_rst_data", dout, 32'd0);

    // randomized scans, including over-shift and bypass
    for (int k = 0; k < 24; k++) begin
      w = $urandom;
      case ($urandom_range(0, 4))
        0: n = 8;
        1: n = 40;
        2: n = $urandom_range(0, 70);
        default: n = W;
      endcase
      do_capture(w, w, ($urandom_range(0, 3) == 0), 1'b0, 1'b0);
      for (int i = 0; i < n; i++) do_shift(1'($urandom));
      do_update();
      if ($urandom_range(0, 3) == 0) do_shift(1'b1);
    end

    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("upd_q_empty", 32'(upd_q.size()), 32'd0);
    chk("tdo_q_empty", 32'(tdo_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
